// File: rtl/rom_streamer_pkg.sv
// Shared types for the ROM streamer: FSM states, in-flight tag and FIFO sizing.
package rom_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // One slot per ROM pipeline stage plus the head slot being popped.
  function automatic int fifo_depth(input int rom_latency);
    return rom_latency + 1;
  endfunction

endpackage

// File: rtl/rom_streamer_fifo.sv
// Small synchronous FIFO with a registered head word, a body array and a flush.
module rom_streamer_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 33,
  parameter int CNTW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CNTW-1:0]  count
);

  localparam int BODY = DEPTH - 1;
  localparam int PW   = (BODY > 1) ? $clog2(BODY) : 1;

  logic [WIDTH-1:0] mem [BODY];
  logic [WIDTH-1:0] head_data_reg;
  logic             head_valid_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CNTW-1:0]  body_count_reg;

  logic head_free;
  logic body_empty;
  logic load_from_body;
  logic bypass;
  logic body_write;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(BODY - 1)) ? '0 : p + PW'(1);
  endfunction

  // The head refills from the body first, so order is preserved; an empty body lets a push go straight to the head.
  assign head_free      = !head_valid_reg || pop;
  assign body_empty     = (body_count_reg == '0);
  assign load_from_body = head_free && !body_empty;
  assign bypass         = head_free && body_empty && push;
  assign body_write     = push && !bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_reg  <= '0;
      head_valid_reg <= 1'b0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      body_count_reg <= '0;
    end else if (flush) begin
      head_data_reg  <= '0;
      head_valid_reg <= 1'b0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      body_count_reg <= '0;
    end else begin
      if (load_from_body) begin
        head_data_reg  <= mem[rd_ptr_reg];
        head_valid_reg <= 1'b1;
        rd_ptr_reg     <= ptr_next(rd_ptr_reg);
      end else if (bypass) begin
        head_data_reg  <= din;
        head_valid_reg <= 1'b1;
      end else if (head_free) begin
        head_valid_reg <= 1'b0;
      end
      if (body_write) begin
        wr_ptr_reg <= ptr_next(wr_ptr_reg);
      end
      if (body_write && !load_from_body) begin
        body_count_reg <= body_count_reg + CNTW'(1);
      end else if (!body_write && load_from_body) begin
        body_count_reg <= body_count_reg - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (body_write && !flush) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  assign dout       = head_data_reg;
  assign dout_valid = head_valid_reg;
  assign count      = body_count_reg + CNTW'(head_valid_reg);

endmodule

// File: rtl/rom_streamer.sv
// Streams COUNT consecutive ROM words as a valid/ready stream with LAST on the final word.
// Optional macro ROM_STREAMER_ABORT_EN adds an abort input that cancels a run in progress.
module rom_streamer
  import rom_streamer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SIZE        = 1024,
  parameter int ROM_LATENCY = 2,
  parameter int CW          = 16,
  parameter int AW          = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    first_addr,
  input  logic [CW-1:0]    count,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_do,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             last,
  output logic             busy,
  output logic             done
`ifdef ROM_STREAMER_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int DEPTH = fifo_depth(ROM_LATENCY);
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int OCCW  = 4;

  state_t          state_reg;
  logic [AW-1:0]   addr_reg;
  logic [AW-1:0]   last_addr_reg;
  logic [CW-1:0]   remaining_reg;
  tag_t            pipe_reg [ROM_LATENCY];
  logic            busy_reg;
  logic            done_reg;

  logic [CNTW-1:0] fifo_count;
  logic [WIDTH:0]  fifo_dout;
  logic            fifo_valid;
  logic [OCCW-1:0] inflight;
  logic [OCCW-1:0] occupancy;
  logic            credit_ok;
  logic            issue;
  logic            xfer;
  logic            capture;
  logic            abort_hit;

`ifdef ROM_STREAMER_ABORT_EN
  assign abort_hit = abort && (state_reg != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight = inflight + OCCW'(pipe_reg[i].valid);
    end
  end

  // A word popped this cycle frees its slot now, which is what lets DEPTH entries sustain full rate.
  assign xfer      = fifo_valid && ready;
  assign occupancy = OCCW'(fifo_count) + inflight;
  assign credit_ok = occupancy < (OCCW'(DEPTH) + OCCW'(xfer));
  assign issue     = (state_reg == ISSUE) && credit_ok && !abort_hit;
  assign rom_addr  = issue ? addr_reg : last_addr_reg;
  assign capture   = pipe_reg[ROM_LATENCY-1].valid;

  // Tag pipe tracks which ROM output cycles carry requested words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_reg[i] <= '0;
      end
    end else if (abort_hit) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_reg[i] <= '0;
      end
    end else begin
      pipe_reg[0] <= issue ? tag_t'{valid: 1'b1, last: (remaining_reg == CW'(1))} : tag_t'('0);
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      last_addr_reg <= '0;
      remaining_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (issue) begin
        last_addr_reg <= addr_reg;
        addr_reg      <= (addr_reg == AW'(SIZE - 1)) ? '0 : addr_reg + AW'(1);
        remaining_reg <= remaining_reg - CW'(1);
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              addr_reg      <= first_addr;
              remaining_reg <= count;
              state_reg     <= ISSUE;
              busy_reg      <= 1'b1;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue && remaining_reg == CW'(1)) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer && fifo_dout[0] && inflight == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (abort_hit) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b1;
      end
    end
  end

  rom_streamer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH + 1),
    .CNTW  (CNTW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (abort_hit),
    .push       (capture),
    .din        ({rom_do, pipe_reg[ROM_LATENCY-1].last}),
    .pop        (xfer),
    .dout       (fifo_dout),
    .dout_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign data  = fifo_dout[WIDTH:1];
  assign last  = fifo_dout[0];
  assign valid = fifo_valid;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule
